sdram_bist: RTL and testbench

SDRAM_BIST -- requirements
Module: sdram_bist

---
 rtl/sdram_bist_pkg.sv | 28 ++
 rtl/sdram_bist_patgen.sv | 66 ++++++
 rtl/sdram_bist.sv | 194 +++++++++++++++++++
 tb/tb_sdram_bist.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_bist_pkg.sv
// Shared types and constants for the SDRAM built-in self test.
// The LFSR constants are only consumed when SDRAM_BIST_LFSR_EN is defined.
package sdram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INIT,
    ST_WR_REQ,
    ST_WR_DATA,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_DONE
  } state_e;

  localparam logic [1:0] PAT_INCR = 2'd0;
  localparam logic [1:0] PAT_LFSR = 2'd1;
  localparam logic [1:0] PAT_WALK = 2'd2;
  localparam logic [1:0] PAT_ADDR = 2'd3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Terms x^16,x^14,x^13,x^11 tapped at bits 0,2,3,5 of a right-shifting register.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/sdram_bist_patgen.sv
// Test pattern generator: produces the word for sequence index k.
// LFSR pattern present only with SDRAM_BIST_LFSR_EN; otherwise code 1 falls back to incr.
module sdram_bist_patgen
  import sdram_bist_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [1:0]        pattern_i,
  input  logic [ADDR_W-1:0] index_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] word_o
);

  // One-hot rotator equals 1 << (k mod DATA_W) without a divider.
  logic [DATA_W-1:0] walk_q, walk_d;

  always_comb begin
    walk_d = walk_q;
    if (clear_i) begin
      walk_d = DATA_W'(1);
    end else if (advance_i) begin
      walk_d = (walk_q << 1) | (walk_q >> (DATA_W - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) walk_q <= DATA_W'(1);
    else     walk_q <= walk_d;
  end

`ifdef SDRAM_BIST_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (clear_i) begin
      lfsr_d = LFSR_SEED;
    end else if (advance_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
`endif

  always_comb begin
    word_o = DATA_W'(index_i);
    case (pattern_i)
`ifdef SDRAM_BIST_LFSR_EN
      PAT_LFSR: word_o = DATA_W'(lfsr_q);
`endif
      PAT_WALK: word_o = walk_q;
      PAT_ADDR: word_o = DATA_W'(addr_i);
      default:  word_o = DATA_W'(index_i);
    endcase
  end

endmodule

// File: rtl/sdram_bist.sv
// SDRAM BIST: writes NUM_BURSTS bursts of a pattern, reads them back and counts mismatches.
// Define SDRAM_BIST_LFSR_EN to make the LFSR pattern (pattern_sel=1) available.
module sdram_bist
  import sdram_bist_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 9,
  parameter int BURST_LEN  = 8,
  parameter int NUM_BURSTS = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  input  logic              sdram_init_done,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  input  logic [DATA_W-1:0] sdram_dout,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  wr_length,
  output logic [LEN_W-1:0]  rd_length,
  output logic [DATA_W-1:0] sdram_din,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  state_e            state_q, state_d;
  logic [1:0]        pat_q, pat_d;
  logic [ADDR_W-1:0] burst_q, burst_d;
  logic [LEN_W-1:0]  word_q, word_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              pass_q, pass_d;

  logic              wr_clr, wr_adv, rd_clr, rd_adv;
  logic [DATA_W-1:0] wr_word, rd_word;
  logic [ADDR_W-1:0] index, burst_addr, word_addr;
  logic              word_last, burst_last, wr_active, rd_active;

  assign index      = burst_q * ADDR_W'(BURST_LEN) + ADDR_W'(word_q);
  assign burst_addr = ADDR_W'(BASE_ADDR) + burst_q * ADDR_W'(BURST_LEN);
  assign word_addr  = ADDR_W'(BASE_ADDR) + index;
  assign word_last  = (word_q == LEN_W'(BURST_LEN - 1));
  assign burst_last = (burst_q == ADDR_W'(NUM_BURSTS - 1));

  sdram_bist_patgen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_gen (
    .clk       (clk),
    .rst       (reset),
    .clear_i   (wr_clr),
    .advance_i (wr_adv),
    .pattern_i (pat_q),
    .index_i   (index),
    .addr_i    (word_addr),
    .word_o    (wr_word)
  );

  sdram_bist_patgen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_gen (
    .clk       (clk),
    .rst       (reset),
    .clear_i   (rd_clr),
    .advance_i (rd_adv),
    .pattern_i (pat_q),
    .index_i   (index),
    .addr_i    (word_addr),
    .word_o    (rd_word)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    burst_d = burst_q;
    word_d  = word_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;
    wr_clr  = 1'b0;
    wr_adv  = 1'b0;
    rd_clr  = 1'b0;
    rd_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef SDRAM_BIST_LFSR_EN
          pat_d = pattern_sel;
`else
          pat_d = (pattern_sel == PAT_LFSR) ? PAT_INCR : pattern_sel;
`endif
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          wr_clr  = 1'b1;
          rd_clr  = 1'b1;
          state_d = ST_WAIT_INIT;
        end
      end
      ST_WAIT_INIT: begin
        if (sdram_init_done) begin
          burst_d = '0;
          word_d  = '0;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ, ST_WR_DATA: begin
        if (sdram_wr_ack) begin
          wr_adv  = 1'b1;
          state_d = ST_WR_DATA;
          if (word_last) begin
            word_d = '0;
            if (burst_last) begin
              // Read expectation restarts from the seed so index k matches the write.
              burst_d = '0;
              rd_clr  = 1'b1;
              state_d = ST_RD_REQ;
            end else begin
              burst_d = burst_q + ADDR_W'(1);
              state_d = ST_WR_REQ;
            end
          end else begin
            word_d = word_q + LEN_W'(1);
          end
        end
      end
      ST_RD_REQ, ST_RD_DATA: begin
        if (sdram_rd_ack) begin
          rd_adv  = 1'b1;
          state_d = ST_RD_DATA;
          if (sdram_dout != rd_word) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0)    first_d = word_addr;
          end
          if (word_last) begin
            word_d = '0;
            if (burst_last) begin
              pass_d  = (err_d == 16'd0);
              state_d = ST_DONE;
            end else begin
              burst_d = burst_q + ADDR_W'(1);
              state_d = ST_RD_REQ;
            end
          end else begin
            word_d = word_q + LEN_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pat_q   <= PAT_INCR;
      burst_q <= '0;
      word_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      burst_q <= burst_d;
      word_q  <= word_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  // Bus outputs decode straight from state so reset clears them asynchronously.
  assign wr_active      = (state_q == ST_WR_REQ) || (state_q == ST_WR_DATA);
  assign rd_active      = (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
  assign sdram_wr_req   = (state_q == ST_WR_REQ);
  assign sdram_rd_req   = (state_q == ST_RD_REQ);
  assign wr_addr        = wr_active ? burst_addr : '0;
  assign rd_addr        = rd_active ? burst_addr : '0;
  assign wr_length      = wr_active ? LEN_W'(BURST_LEN) : '0;
  assign rd_length      = rd_active ? LEN_W'(BURST_LEN) : '0;
  assign sdram_din      = wr_active ? wr_word : '0;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_sdram_bist.sv
// Self-checking bench for sdram_bist: SDRAM model with fault injection plus a reference checker.
// Expectations for pattern 1 follow SDRAM_BIST_LFSR_EN.
module tb_sdram_bist;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  pattern_sel;
  logic        sdram_init_done;
  logic        sdram_wr_ack;
  logic        sdram_rd_ack;
  logic [15:0] sdram_dout;
  logic        sdram_wr_req, sdram_rd_req;
  logic [23:0] wr_addr, rd_addr;
  logic [8:0]  wr_length, rd_length;
  logic [15:0] sdram_din;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [23:0] first_err_addr;

  sdram_bist dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .pattern_sel     (pattern_sel),
    .sdram_init_done (sdram_init_done),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_rd_ack    (sdram_rd_ack),
    .sdram_dout      (sdram_dout),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_rd_req    (sdram_rd_req),
    .wr_addr         (wr_addr),
    .rd_addr         (rd_addr),
    .wr_length       (wr_length),
    .rd_length       (rd_length),
    .sdram_din       (sdram_din),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_addr  (first_err_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int corrupt_mode = 0;
  int wr_idx = -1;
  logic [15:0] mem [0:63];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1, shifting right: new MSB from bits 0,2,3,5.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic logic [15:0] exp_word(input int pat, input int k);
    logic [15:0] s;
    s = 16'hACE1;
    case (pat)
`ifdef SDRAM_BIST_LFSR_EN
      1: begin
        for (int i = 0; i < k; i++) s = lfsr_step(s);
        return s;
      end
`else
      1: return 16'(k);
`endif
      2: return 16'h1 << (k % 16);
      3: return 16'(k);
      default: return 16'(k);
    endcase
  endfunction

  function automatic logic [15:0] rd_value(input logic [15:0] d, input int addr);
    if (corrupt_mode == 1 && addr == 19) return d ^ 16'h0001;
    if (corrupt_mode == 2) return 16'h0000;
    return d;
  endfunction

  // SDRAM model: acks each word (one stall cycle mid-burst), stores writes, returns reads.
  initial begin
    int a;
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    sdram_dout   = 16'h0;
    forever begin
      @(negedge clk);
      if (!reset && sdram_wr_req) begin
        a = int'(wr_addr);
        for (int i = 0; i < 8; i++) begin
          if (i == 2) begin
            sdram_wr_ack = 1'b0;
            @(negedge clk);
            if (reset) break;
          end
          sdram_wr_ack = 1'b1;
          wr_idx = i;
          mem[a + i] = sdram_din;
          @(negedge clk);
          if (reset) break;
        end
        sdram_wr_ack = 1'b0;
        wr_idx = -1;
      end else if (!reset && sdram_rd_req) begin
        a = int'(rd_addr);
        for (int i = 0; i < 8; i++) begin
          if (i == 5) begin
            sdram_rd_ack = 1'b0;
            @(negedge clk);
            if (reset) break;
          end
          sdram_rd_ack = 1'b1;
          sdram_dout = rd_value(mem[a + i], a + i);
          @(negedge clk);
          if (reset) break;
        end
        sdram_rd_ack = 1'b0;
      end
    end
  end

  // Reference checker: burst addresses, written words, and end-of-pass results.
  initial begin
    int wk = 0, rk = 0, eerr = 0, efirst = -1, cpat = 0;
    logic wreq_p = 1'b0, rreq_p = 1'b0, done_p = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        wreq_p = 1'b0;
        rreq_p = 1'b0;
        done_p = 1'b0;
        continue;
      end
      if (start && !busy) begin
        wk = 0; rk = 0; eerr = 0; efirst = -1;
        cpat = int'(pattern_sel);
      end
      if (sdram_wr_req && !wreq_p) begin
        chk("wr_addr", 32'(wr_addr), 32'(wk));
        chk("wr_length", 32'(wr_length), 32'd8);
      end
      if (sdram_rd_req && !rreq_p) begin
        chk("rd_addr", 32'(rd_addr), 32'(rk));
        chk("rd_length", 32'(rd_length), 32'd8);
      end
      if (sdram_wr_ack) begin
        chk("wr_data", 32'(sdram_din), 32'(exp_word(cpat, wk)));
        wk++;
      end
      if (sdram_rd_ack) begin
        if (sdram_dout !== exp_word(cpat, rk)) begin
          eerr++;
          if (efirst < 0) efirst = rk;
        end
        rk++;
      end
      if (done) begin
        chk("done_err_count", 32'(err_count), 32'(eerr));
        chk("done_first_err", 32'(first_err_addr), (efirst < 0) ? 32'd0 : 32'(efirst));
        chk("done_pass", 32'(pass), (eerr == 0) ? 32'd1 : 32'd0);
        chk("done_words", 32'(wk + rk), 32'd64);
      end
      if (done_p) begin
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
      end
      wreq_p = sdram_wr_req;
      rreq_p = sdram_rd_req;
      done_p = done;
    end
  end

  task automatic run_start(input logic [1:0] p);
    @(negedge clk);
    pattern_sel = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    start = 1'b0;
    pattern_sel = 2'd0;
    sdram_init_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wr_req", 32'(sdram_wr_req), 32'd0);
    chk("rst_rd_req", 32'(sdram_rd_req), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_wr_len", 32'(wr_length), 32'd0);
    chk("rst_rd_len", 32'(rd_length), 32'd0);
    chk("rst_din", 32'(sdram_din), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_first_err", 32'(first_err_addr), 32'd0);
    reset = 1'b0;

    // Incrementing pattern, ideal memory.
    run_start(2'd0);
    wait_done("incr_done");
    chk("incr_pass", 32'(pass), 32'd1);
    chk("incr_err", 32'(err_count), 32'd0);
    chk("incr_mem0", 32'(mem[0]), 32'd0);
    chk("incr_mem13", 32'(mem[13]), 32'd13);
    chk("incr_mem31", 32'(mem[31]), 32'd31);

    // Address pattern, bit 0 of word 19 corrupted on read.
    corrupt_mode = 1;
    run_start(2'd3);
    wait_done("addr_done");
    chk("addr_pass", 32'(pass), 32'd0);
    chk("addr_err", 32'(err_count), 32'd1);
    chk("addr_first", 32'(first_err_addr), 32'd19);
    corrupt_mode = 0;
    repeat (3) @(negedge clk);
    chk("result_hold_err", 32'(err_count), 32'd1);
    chk("result_hold_pass", 32'(pass), 32'd0);

    // SDRAM not initialised for 100 cycles.
    sdram_init_done = 1'b0;
    run_start(2'd0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sdram_wr_req || sdram_rd_req || !busy) bad++;
    end
    chk("init_wait_hold", 32'(bad), 32'd0);
    chk("init_clears_err", 32'(err_count), 32'd0);
    sdram_init_done = 1'b1;
    wait_done("init_done");
    chk("init_pass", 32'(pass), 32'd1);

    // Reset during write word 3, then a clean run.
    run_start(2'd0);
    bad = 1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (sdram_wr_ack && wr_idx == 3) begin
        bad = 0;
        break;
      end
    end
    chk("reach_word3", 32'(bad), 32'd0);
    #3 reset = 1'b1;
    #1;
    chk("midrst_wr_req", 32'(sdram_wr_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || sdram_wr_req || sdram_rd_req) bad++;
    end
    chk("no_resume", 32'(bad), 32'd0);
    run_start(2'd0);
    wait_done("post_rst_done");
    chk("post_rst_pass", 32'(pass), 32'd1);

    // Pattern 1: LFSR when enabled, otherwise incrementing.
    run_start(2'd1);
    wait_done("pat1_done");
    chk("pat1_pass", 32'(pass), 32'd1);
`ifdef SDRAM_BIST_LFSR_EN
    chk("pat1_mem0", 32'(mem[0]), 32'h0000ACE1);
    chk("pat1_mem1", 32'(mem[1]), 32'h00005670);
    chk("pat1_mem2", 32'(mem[2]), 32'h0000AB38);
`else
    chk("pat1_mem0", 32'(mem[0]), 32'd0);
    chk("pat1_mem1", 32'(mem[1]), 32'd1);
    chk("pat1_mem2", 32'(mem[2]), 32'd2);
`endif

    // Walking-one with a start pulse mid-run that must be ignored.
    run_start(2'd2);
    repeat (20) @(negedge clk);
    run_start(2'd0);
    wait_done("walk_done");
    chk("walk_pass", 32'(pass), 32'd1);
    chk("walk_mem17", 32'(mem[17]), 32'h00000002);

    // Walking-one against a stuck-at-zero data bus.
    corrupt_mode = 2;
    run_start(2'd2);
    wait_done("stuck_done");
    chk("stuck_err", 32'(err_count), 32'd32);
    chk("stuck_first", 32'(first_err_addr), 32'd0);
    chk("stuck_pass", 32'(pass), 32'd0);
    corrupt_mode = 0;

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
